sys_top: RTL and testbench

SYS_TOP -- requirements
Module: sys_top

---
 rtl/sys_top_pkg.sv | 40 ++++
 rtl/sys_top_if.sv | 14 +
 rtl/sys_top_uart_core.sv | 183 ++++++++++++++++++
 rtl/sys_top.sv | 135 +++++++++++++
 tb/tb_sys_top.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sys_top_pkg.sv
// Shared definitions for the UART command processor: command bytes,
// ALU function codes and the state encodings of every FSM in the block.
package sys_top_pkg;

    // Leading command bytes recognised in IDLE
    localparam logic [7:0] CMD_WR  = 8'hAA;
    localparam logic [7:0] CMD_RD  = 8'hBB;
    localparam logic [7:0] CMD_OP  = 8'hCC;
    localparam logic [7:0] CMD_NOP = 8'hDD;

    // ALU function codes, taken from the low nibble of the function byte
    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_MUL   = 4'h2,
        ALU_DIV   = 4'h3,
        ALU_AND   = 4'h4,
        ALU_OR    = 4'h5,
        ALU_NAND  = 4'h6,
        ALU_NOR   = 4'h7,
        ALU_XOR   = 4'h8,
        ALU_NOTA  = 4'h9,
        ALU_XNOR  = 4'hA,
        ALU_EQ    = 4'hB,
        ALU_GT    = 4'hC,
        ALU_SHR   = 4'hD,
        ALU_SHL   = 4'hE,
        ALU_PASSA = 4'hF
    } alu_fun_t;

    // Command FSM
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUN, NOP_FUN, EXEC, SEND
    } cmd_state_t;

    // UART receiver / transmitter
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/sys_top_if.sv
// Byte-level handshake between the command logic (master) and the UART
// core (slave): received bytes flow up, bytes to transmit flow down.
interface sys_top_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_busy;

    modport master (input rx_valid, rx_data, tx_busy, output tx_load, tx_data);
    modport slave  (output rx_valid, rx_data, tx_busy, input tx_load, tx_data);
endinterface

// File: rtl/sys_top_uart_core.sv
// 8N1 UART receiver and transmitter sharing one bit period. The receiver
// synchronises the line, rejects start glitches and drops framing errors;
// the transmitter holds a busy flag for the whole frame.
module uart_core #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 217
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_in,
    output logic      tx_out,
    sys_top_if.slave  bus
);
    import sys_top_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int HALF  = CLKS_PER_BIT / 2;

    // ---------------- receiver ----------------
    rx_state_t             rx_state, rx_state_nxt;
    logic                  rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]      rx_cnt;
    logic [BIT_W-1:0]      rx_bit;
    logic [DATA_WIDTH-1:0] rx_shreg, rx_data_q;
    logic                  rx_valid_q;
    logic                  rx_tick, rx_half, rx_fall;

    assign rx_tick = (rx_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign rx_half = (rx_cnt == CNT_W'(HALF - 1));
    assign rx_fall = rx_prev & ~rx_sync;

    // Two-flop synchroniser plus an edge-detect flop; idle level is high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_nxt;
    end

    // Receiver next state: a start bit still high at mid-bit is a glitch
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
            RX_START: if (rx_half) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == BIT_W'(DATA_WIDTH - 1)) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    // Receiver datapath: bit-centre sampling, LSB first, one-cycle valid
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shreg   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
                RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + CNT_W'(1);
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_sync, rx_shreg[DATA_WIDTH-1:1]};
                        rx_bit   <= rx_bit + BIT_W'(1);
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    rx_cnt <= rx_tick ? '0 : rx_cnt + CNT_W'(1);
                    if (rx_tick && rx_sync) begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_shreg;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;

    // ---------------- transmitter ----------------
    tx_state_t             tx_state, tx_state_nxt;
    logic [CNT_W-1:0]      tx_cnt;
    logic [BIT_W-1:0]      tx_bit;
    logic [DATA_WIDTH-1:0] tx_shreg;
    logic                  tx_tick;

    assign tx_tick     = (tx_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign bus.tx_busy = (tx_state != TX_IDLE);

    // Transmitter state register
    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_nxt;
    end

    // Transmitter next state; loads are only accepted while idle
    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (bus.tx_load) tx_state_nxt = TX_START;
            TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == BIT_W'(DATA_WIDTH - 1)) tx_state_nxt = TX_STOP;
            TX_STOP:  if (tx_tick) tx_state_nxt = TX_IDLE;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    // Transmitter datapath; the line is registered so it never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_out   <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (bus.tx_load) begin
                        tx_shreg <= bus.tx_data;
                        tx_out   <= 1'b0;
                    end else begin
                        tx_out <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_out   <= tx_shreg[0];
                        tx_shreg <= tx_shreg >> 1;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_bit == BIT_W'(DATA_WIDTH - 1)) begin
                            tx_out <= 1'b1;
                        end else begin
                            tx_out   <= tx_shreg[0];
                            tx_shreg <= tx_shreg >> 1;
                            tx_bit   <= tx_bit + BIT_W'(1);
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    tx_out <= 1'b1;
                    tx_cnt <= tx_tick ? '0 : tx_cnt + CNT_W'(1);
                end
                default: tx_out <= 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/sys_top.sv
// UART-controlled register file and ALU. Commands arrive as byte
// sequences on RX_IN; reads and ALU results are returned on TX_OUT.
module sys_top #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 217
) (
    input  logic Ref_clk,
    input  logic RST,
    input  logic RX_IN,
    output logic TX_OUT
);
    import sys_top_pkg::*;

    localparam int RF_DEPTH = 1 << ADDR_WIDTH;

    sys_top_if #(.DATA_WIDTH(DATA_WIDTH)) u_bus ();

    uart_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (Ref_clk),
        .rst   (RST),
        .rx_in (RX_IN),
        .tx_out(TX_OUT),
        .bus   (u_bus)
    );

    cmd_state_t            state, state_nxt;
    logic [DATA_WIDTH-1:0] rf [RF_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_addr;
    alu_fun_t              fun_q;
    logic [DATA_WIDTH-1:0] op_a, op_b, alu_res;
    logic                  byte_in;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] tx_data;

    assign byte_in       = u_bus.rx_valid;
    assign rx_byte       = u_bus.rx_data;
    assign rx_addr       = rx_byte[ADDR_WIDTH-1:0];
    assign op_a          = rf[0];
    assign op_b          = rf[1];
    assign u_bus.tx_load = tx_load;
    assign u_bus.tx_data = tx_data;

    // Command FSM state register
    always_ff @(posedge Ref_clk) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Command decode; bytes arriving while in SEND are simply not looked at
    always_comb begin
        state_nxt = state;
        tx_load   = 1'b0;
        tx_data   = alu_res;
        case (state)
            IDLE: begin
                if (byte_in) begin
                    if      (rx_byte == DATA_WIDTH'(CMD_WR))  state_nxt = WR_ADDR;
                    else if (rx_byte == DATA_WIDTH'(CMD_RD))  state_nxt = RD_ADDR;
                    else if (rx_byte == DATA_WIDTH'(CMD_OP))  state_nxt = OP_A;
                    else if (rx_byte == DATA_WIDTH'(CMD_NOP)) state_nxt = NOP_FUN;
                end
            end
            WR_ADDR: if (byte_in) state_nxt = WR_DATA;
            WR_DATA: if (byte_in) state_nxt = IDLE;
            RD_ADDR: begin
                if (byte_in) begin
                    tx_load   = 1'b1;
                    tx_data   = rf[rx_addr];
                    state_nxt = SEND;
                end
            end
            OP_A:    if (byte_in) state_nxt = OP_B;
            OP_B:    if (byte_in) state_nxt = OP_FUN;
            OP_FUN:  if (byte_in) state_nxt = EXEC;
            NOP_FUN: if (byte_in) state_nxt = EXEC;
            EXEC: begin
                tx_load   = 1'b1;
                tx_data   = alu_res;
                state_nxt = SEND;
            end
            SEND:    if (!u_bus.tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Register file writes and latched address/function operands
    always_ff @(posedge Ref_clk) begin
        if (RST) begin
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
            wr_addr <= '0;
            fun_q   <= ALU_ADD;
        end else if (byte_in) begin
            case (state)
                WR_ADDR: wr_addr <= rx_addr;
                WR_DATA: rf[wr_addr] <= rx_byte;
                OP_A:    rf[0] <= rx_byte;
                OP_B:    rf[1] <= rx_byte;
                OP_FUN,
                NOP_FUN: fun_q <= alu_fun_t'(rx_byte[3:0]);
                default: ;
            endcase
        end
    end

    // ALU on RF[0]/RF[1]; all results truncated to the data width
    always_comb begin
        alu_res = '0;
        case (fun_q)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_MUL:   alu_res = op_a * op_b;
            ALU_DIV:   alu_res = (op_b == '0) ? '0 : op_a / op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_OR:    alu_res = op_a | op_b;
            ALU_NAND:  alu_res = ~(op_a & op_b);
            ALU_NOR:   alu_res = ~(op_a | op_b);
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_NOTA:  alu_res = ~op_a;
            ALU_XNOR:  alu_res = ~(op_a ^ op_b);
            ALU_EQ:    alu_res = DATA_WIDTH'(op_a == op_b);
            ALU_GT:    alu_res = DATA_WIDTH'(op_a > op_b);
            ALU_SHR:   alu_res = op_a >> 1;
            ALU_SHL:   alu_res = op_a << 1;
            ALU_PASSA: alu_res = op_a;
            default:   alu_res = '0;
        endcase
    end

endmodule

// File: tb/tb_sys_top.sv
// Scoreboard bench for sys_top: commands are sent serially, the expected
// response byte is queued, and a UART decoder on TX_OUT feeds a monitor.
module tb_sys_top;

    localparam int CPB     = 16;
    localparam int LAT_MAX = CPB / 2 + 8;

    logic Ref_clk;
    logic RST;
    logic RX_IN;
    logic TX_OUT;

    sys_top_if #(.DATA_WIDTH(8)) mon_if ();

    sys_top #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Ref_clk(Ref_clk),
        .RST    (RST),
        .RX_IN  (RX_IN),
        .TX_OUT (TX_OUT)
    );

    logic [7:0] exp_q[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_stop_cyc = 0;
    bit ignore_rx = 0;
    bit in_frame = 0;

    initial begin
        Ref_clk = 1'b0;
        forever #5 Ref_clk = ~Ref_clk;
    end

    always @(posedge Ref_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Serial byte onto RX_IN, driven on falling edges
    task automatic send_byte(input logic [7:0] b, input bit stop_bit);
        mon_if.tx_data = b;
        mon_if.tx_busy = 1'b1;
        RX_IN = 1'b0;
        repeat (CPB) @(negedge Ref_clk);
        for (int i = 0; i < 8; i++) begin
            RX_IN = b[i];
            repeat (CPB) @(negedge Ref_clk);
        end
        last_stop_cyc = cyc;
        RX_IN = stop_bit;
        repeat (CPB) @(negedge Ref_clk);
        RX_IN = 1'b1;
        repeat (2) @(negedge Ref_clk);
        mon_if.tx_busy = 1'b0;
    endtask

    task automatic send_cmd(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input bit has_resp, input logic [7:0] exp);
        logic [7:0] bytes [4];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        if (has_resp) exp_q.push_back(exp);
        for (int i = 0; i < n; i++) send_byte(bytes[i], 1'b1);
        repeat (has_resp ? 12 * CPB : 2 * CPB) @(negedge Ref_clk);
    endtask

    // UART decoder on TX_OUT: mid-bit sampling, posts each byte to mon_if
    initial begin
        logic [7:0] b;
        int start_cyc;
        mon_if.rx_valid = 1'b0;
        mon_if.rx_data  = 8'h00;
        forever begin
            @(negedge Ref_clk);
            if (TX_OUT === 1'b0) begin
                start_cyc = cyc;
                in_frame  = 1;
                repeat (CPB / 2) @(negedge Ref_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge Ref_clk);
                    b[i] = TX_OUT;
                end
                repeat (CPB) @(negedge Ref_clk);
                in_frame = 0;
                if (!ignore_rx) begin
                    chk("stop_bit", int'(TX_OUT), 1);
                    n_chk++;
                    if (start_cyc - last_stop_cyc <= LAT_MAX) n_pass++;
                    else $display("FAIL latency: got %0d cycles, expected <= %0d",
                                  start_cyc - last_stop_cyc, LAT_MAX);
                    mon_if.rx_data  = b;
                    mon_if.rx_valid = 1'b1;
                    @(negedge Ref_clk);
                    mon_if.rx_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: every decoded byte is matched against the scoreboard
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge Ref_clk);
            if (mon_if.rx_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_resp: got 0x%02h, expected no response", mon_if.rx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp", int'(mon_if.rx_data), int'(e));
                end
            end
        end
    end

    initial begin
        int k;
        RST = 1'b1;
        RX_IN = 1'b1;
        mon_if.tx_load = 1'b0;
        mon_if.tx_data = 8'h00;
        mon_if.tx_busy = 1'b0;
        repeat (3) @(negedge Ref_clk);
        chk("reset_tx_out", int'(TX_OUT), 1);
        RST = 1'b0;
        repeat (5) @(negedge Ref_clk);
        chk("idle_tx_out", int'(TX_OUT), 1);

        // write / read back
        send_cmd(3, 8'hAA, 8'h05, 8'hAB, 8'h00, 0, 8'h00);
        send_cmd(2, 8'hBB, 8'h05, 8'h00, 8'h00, 1, 8'hAB);
        // operand load + add, then read operands back
        send_cmd(4, 8'hCC, 8'h10, 8'h25, 8'h00, 1, 8'h35);
        send_cmd(2, 8'hBB, 8'h00, 8'h00, 8'h00, 1, 8'h10);
        send_cmd(2, 8'hBB, 8'h01, 8'h00, 8'h00, 1, 8'h25);
        // ALU on stored operands; divide by zero
        send_cmd(2, 8'hDD, 8'h09, 8'h00, 8'h00, 1, 8'hEF);
        send_cmd(3, 8'hAA, 8'h01, 8'h00, 8'h00, 0, 8'h00);
        send_cmd(2, 8'hDD, 8'h03, 8'h00, 8'h00, 1, 8'h00);
        // wrap and truncation
        send_cmd(4, 8'hCC, 8'h05, 8'h07, 8'h01, 1, 8'hFE);
        send_cmd(4, 8'hCC, 8'h20, 8'h10, 8'h02, 1, 8'h00);
        // upper nibble of function/address bytes ignored
        send_cmd(2, 8'hDD, 8'h3C, 8'h00, 8'h00, 1, 8'h01);
        send_cmd(2, 8'hDD, 8'h0D, 8'h00, 8'h00, 1, 8'h10);
        send_cmd(2, 8'hDD, 8'hFE, 8'h00, 8'h00, 1, 8'h40);
        send_cmd(2, 8'hDD, 8'h06, 8'h00, 8'h00, 1, 8'hFF);
        send_cmd(2, 8'hDD, 8'h0B, 8'h00, 8'h00, 1, 8'h00);
        send_cmd(3, 8'hAA, 8'hF3, 8'h5A, 8'h00, 0, 8'h00);
        send_cmd(2, 8'hBB, 8'h13, 8'h00, 8'h00, 1, 8'h5A);

        // unknown byte and a framing-error 0xBB must both be dropped
        send_byte(8'h55, 1'b1);
        send_byte(8'hBB, 1'b0);
        repeat (2 * CPB) @(negedge Ref_clk);
        send_cmd(2, 8'hBB, 8'h05, 8'h00, 8'h00, 1, 8'hAB);

        // reset in the middle of a response (bit 2 of 0xAB is a 0)
        ignore_rx = 1;
        send_cmd(2, 8'hBB, 8'h05, 8'h00, 8'h00, 0, 8'h00);
        k = 0;
        while (!in_frame && k < 40 * CPB) begin
            @(negedge Ref_clk);
            k++;
        end
        n_chk++;
        if (in_frame) n_pass++;
        else $display("FAIL resp_start_timeout: got no start bit within %0d cycles, expected one", 40 * CPB);
        repeat (3 * CPB + CPB / 2) @(negedge Ref_clk);
        RST = 1'b1;
        @(posedge Ref_clk);
        #1;
        chk("tx_out_after_rst", int'(TX_OUT), 1);
        @(negedge Ref_clk);
        RST = 1'b0;
        repeat (12 * CPB) @(negedge Ref_clk);
        ignore_rx = 0;
        send_cmd(2, 8'hBB, 8'h05, 8'h00, 8'h00, 1, 8'h00);

        repeat (4 * CPB) @(negedge Ref_clk);
        chk("pending_responses", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
